// File: rtl/alu_pkg.sv
// Shared encodings for the add/sub datapath and its request scheduler.
// Op codes match the 2-bit flag consumed by add_sub.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } sched_state_t;

endpackage

// File: rtl/add_sub.sv
// Combinational XLEN-bit add, subtract, signed and unsigned set-less-than.
// Both compares reuse the subtractor borrow.
module add_sub
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [1:0]      flag,
  output logic [XLEN-1:0] result
);

  logic [XLEN:0]   diff;
  logic [XLEN-1:0] sum;
  logic            borrow;
  logic            sgn_diff;
  logic            slt;

  assign sum      = in1 + in2;
  assign diff     = {1'b0, in1} - {1'b0, in2};
  assign borrow   = diff[XLEN];
  assign sgn_diff = in1[XLEN-1] ^ in2[XLEN-1];
  // Equal signs: unsigned order equals signed order.
  assign slt      = sgn_diff ? in1[XLEN-1] : borrow;

  always_comb begin
    result = '0;
    unique case (flag)
      OP_ADD:  result = sum;
      OP_SUB:  result = diff[XLEN-1:0];
      OP_SLT:  result = {{(XLEN-1){1'b0}}, slt};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, borrow};
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr with wrap,
// first set request wins.
module rr_arbiter #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one add_sub datapath among NUM_REQ requesters with round-robin
// grant, one-cycle execute and a held valid/ready response.
module addsub_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_in1,
  input  logic [NUM_REQ*XLEN-1:0] req_in2,
  input  logic [NUM_REQ*2-1:0]    req_op,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic                    busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t     state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    cap_id;
  logic [XLEN-1:0]  cap_in1;
  logic [XLEN-1:0]  cap_in2;
  logic [1:0]       cap_op;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_id;
  logic [IW-1:0]      ptr_nxt;
  logic [XLEN-1:0]    result;
  logic [NUM_REQ-1:0] id_oh;
  logic               hs;
  logic               can_grant;
  logic               take;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  add_sub #(
    .XLEN(XLEN)
  ) u_add_sub (
    .in1   (cap_in1),
    .in2   (cap_in2),
    .flag  (cap_op),
    .result(result)
  );

  assign hs        = (state == S_RESP) && rsp_ready[cap_id];
  // Reset gating keeps req_ready low while rst_n is held.
  assign can_grant = rst_n && ((state == S_IDLE) || hs);
  assign take      = can_grant && (|req_valid);
  assign req_ready = can_grant ? gnt : '0;
  assign busy      = (state != S_IDLE);
  assign id_oh     = NUM_REQ'(1) << cap_id;

  assign ptr_nxt = (int'(gnt_id) == NUM_REQ - 1) ?
                   '0 : gnt_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_in1 <= '0;
      cap_in2 <= '0;
      cap_op  <= '0;
      cap_id  <= '0;
      rr_ptr  <= '0;
    end else if (take) begin
      cap_in1 <= req_in1[int'(gnt_id)*XLEN +: XLEN];
      cap_in2 <= req_in2[int'(gnt_id)*XLEN +: XLEN];
      cap_op  <= req_op[int'(gnt_id)*2 +: 2];
      cap_id  <= gnt_id;
      rr_ptr  <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) state <= S_EXEC;
        end
        S_EXEC: begin
          rsp_data  <= result;
          rsp_valid <= id_oh;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (hs) begin
            rsp_valid <= '0;
            state     <= take ? S_EXEC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Self-checking bench for addsub_rr_scheduler with NUM_REQ=2, XLEN=64.
// Vector table, directed sequences and randomized ops vs. a reference model.
module tb_addsub_rr_scheduler;

  localparam int N = 2;
  localparam int X = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*X-1:0] req_in1;
  logic [N*X-1:0] req_in2;
  logic [N*2-1:0] req_op;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [X-1:0]   rsp_data;
  logic           busy;

  addsub_rr_scheduler #(
    .NUM_REQ(N),
    .XLEN   (X)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_in1  (req_in1),
    .req_in2  (req_in2),
    .req_op   (req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   passed;
  int   total;
  int   model_ptr;

  function automatic logic [63:0] ref_op(
    input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: return (a < b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else
      passed++;
  endtask

  task automatic set_req(input int id, input logic [63:0] a,
                         input logic [63:0] b, input logic [1:0] op);
    req_in1[id*X +: X] = a;
    req_in2[id*X +: X] = b;
    req_op[id*2 +: 2]  = op;
  endtask

  // Single op from IDLE; rsp_ready held high by caller.
  task automatic do_op(input int id, input logic [63:0] a,
                       input logic [63:0] b, input logic [1:0] op,
                       input logic [63:0] exp, input string nm);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    @(posedge clk); #1;
    set_req(id, a, b, op);
    req_valid = oh;
    @(negedge clk);
    check({nm, " gnt"}, 64'(req_ready), 64'(oh));
    model_ptr = (id + 1) % N;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check({nm, " exec"}, {62'd0, busy, |rsp_valid}, 64'd2);
    @(negedge clk);
    check({nm, " vld"}, 64'(rsp_valid), 64'(oh));
    check({nm, " data"}, rsp_data, exp);
  endtask

  logic [63:0] m1;
  logic [63:0] exp_d[N];
  int          last_g;
  int          prev_c;
  int          ngr;
  logic [63:0] held;

  initial begin
    passed    = 0;
    total     = 0;
    model_ptr = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_op    = '0;
    rsp_ready = '1;
    m1        = '1;

    vecs[0] = '{0, 64'd5, 64'd3, 2'b00, 64'd8};
    vecs[1] = '{0, 64'd0, 64'd1, 2'b01, m1};
    vecs[2] = '{0, m1, 64'd1, 2'b10, 64'd1};
    vecs[3] = '{0, m1, 64'd1, 2'b11, 64'd0};
    vecs[4] = '{1, 64'h7fff_ffff_ffff_ffff, 64'd1, 2'b00,
                64'h8000_0000_0000_0000};
    vecs[5] = '{1, 64'h8000_0000_0000_0000, 64'd1, 2'b01,
                64'h7fff_ffff_ffff_ffff};
    vecs[6] = '{1, 64'h8000_0000_0000_0000, 64'd1, 2'b10, 64'd1};
    vecs[7] = '{1, 64'h8000_0000_0000_0000, 64'd1, 2'b11, 64'd0};
    vecs[8] = '{0, 64'd3, 64'd3, 2'b10, 64'd0};
    vecs[9] = '{1, m1, m1, 2'b00, 64'hffff_ffff_ffff_fffe};

    #1;
    check("rst outs",
          {rsp_data[59:0], busy, rsp_valid, req_ready[0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op,
            vecs[i].exp, $sformatf("vec%0d", i));

    // Both requesters continuously valid.
    @(posedge clk); #1;
    set_req(0, 64'd10, 64'd20, 2'b00);
    set_req(1, 64'd7, 64'd9, 2'b01);
    exp_d[0] = 64'd30;
    exp_d[1] = 64'hffff_ffff_ffff_fffe;
    req_valid = 2'b11;
    last_g = -1;
    prev_c = -1;
    ngr    = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        check("rr rspid", 64'(rsp_valid), 64'(N'(1) << last_g));
        check("rr data", rsp_data, exp_d[last_g]);
      end
      if (req_ready != '0) begin
        check("rr order", 64'(req_ready), 64'(N'(1) << model_ptr));
        if (prev_c >= 0) check("rr gap", 64'(c - prev_c), 64'd2);
        last_g    = model_ptr;
        model_ptr = (model_ptr + 1) % N;
        prev_c    = c;
        ngr++;
      end
    end
    check("rr count", 64'(ngr), 64'd7);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("rr last", 64'(rsp_valid), 64'(N'(1) << last_g));
    check("rr ldata", rsp_data, exp_d[last_g]);

    // Response held under back-pressure.
    @(posedge clk); #1;
    rsp_ready = '0;
    set_req(0, 64'd100, 64'd1, 2'b01);
    set_req(1, 64'd40, 64'd2, 2'b00);
    req_valid = 2'b01;
    @(negedge clk);
    check("bp gnt", 64'(req_ready), 64'd1);
    model_ptr = 1;
    @(posedge clk); #1;
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    @(negedge clk);
    check("bp exec rdy", 64'(req_ready), 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp vld", 64'(rsp_valid), 64'd1);
      check("bp data", rsp_data, 64'd99);
      check("bp rdy", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp regnt", 64'(req_ready), 64'd2);
    model_ptr = 0;
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    check("bp r1 vld", 64'(rsp_valid), 64'd2);
    check("bp r1 data", rsp_data, 64'd42);

    // Reset during EXEC; requester 0 wins so rr_ptr is 1 before reset.
    @(posedge clk); #1;
    set_req(0, 64'd1, 64'd1, 2'b00);
    set_req(1, 64'd2, 64'd2, 2'b00);
    req_valid = 2'b01;
    @(negedge clk);
    check("rst gnt", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid",
          {rsp_data[59:0], busy, rsp_valid, req_ready[0]}, 64'd0);
    check("rst mid rdy", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post rst", {62'd0, busy, |rsp_valid}, 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    check("post rst ptr", 64'(req_ready), 64'd1);
    model_ptr = 1;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("post rst data", rsp_data, 64'd2);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      int          id;
      logic [63:0] a;
      logic [63:0] b;
      logic [1:0]  op;
      id = $urandom_range(N - 1);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 2'($urandom_range(3));
      if (i % 5 == 0) b = a;
      if (i % 7 == 0) a = {1'b1, 63'd0};
      do_op(id, a, b, op, ref_op(a, b, op),
            $sformatf("rnd%0d", i));
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
